// File: rtl/alu_seq.sv
// Operand sequencer for the 256-bit combinational ALU: holds a small register
// file, issues one command per two cycles and writes the ALU result back.
module alu_seq #(
    parameter int WIDTH = 256,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [AW-1:0]    cmd_src0,
    input  logic [AW-1:0]    cmd_src1,
    input  logic [AW-1:0]    cmd_dst,
    output logic [WIDTH-1:0] alu_op0,
    output logic [WIDTH-1:0] alu_op1,
    output logic [1:0]       alu_mode,
    input  logic [WIDTH-1:0] alu_result,
    output logic             done_valid,
    output logic [AW-1:0]    done_dst,
    output logic [WIDTH-1:0] done_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] op0_q, op1_q, done_data_q;
    logic [1:0]       mode_q;
    logic [AW-1:0]    dst_q, done_dst_q;
    logic             done_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The writeback assignment comes after the load so it wins on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            op0_q        <= '0;
            op1_q        <= '0;
            mode_q       <= '0;
            dst_q        <= '0;
            done_valid_q <= 1'b0;
            done_dst_q   <= '0;
            done_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            done_valid_q <= 1'b0;
            if (load_valid) regs_q[load_addr] <= load_data;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op0_q  <= regs_q[cmd_src0];
                        op1_q  <= regs_q[cmd_src1];
                        mode_q <= cmd_mode;
                        dst_q  <= cmd_dst;
                    end
                end
                EXEC: begin
                    regs_q[dst_q] <= alu_result;
                    done_valid_q  <= 1'b1;
                    done_dst_q    <= dst_q;
                    done_data_q   <= alu_result;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign alu_op0    = op0_q;
    assign alu_op1    = op1_q;
    assign alu_mode   = mode_q;
    assign done_valid = done_valid_q;
    assign done_dst   = done_dst_q;
    assign done_data  = done_data_q;
    assign rd_data    = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a behavioural ALU closes the loop and a
// scoreboard of expected writebacks is filled as commands are driven.
module tb_alu_seq;

    localparam int WIDTH = 256;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    typedef struct {
        logic [AW-1:0]    dst;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             loadValid;
    logic [AW-1:0]    loadAddr;
    logic [WIDTH-1:0] loadData;
    logic             cmdValid;
    logic             cmdReady;
    logic [1:0]       cmdMode;
    logic [AW-1:0]    cmdSrc0, cmdSrc1, cmdDst;
    logic [WIDTH-1:0] aluOp0, aluOp1, aluResult;
    logic [1:0]       aluMode;
    logic             doneValid;
    logic [AW-1:0]    doneDst;
    logic [WIDTH-1:0] doneData;
    logic [AW-1:0]    rdAddr;
    logic [WIDTH-1:0] rdData;

    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] mreg [NREGS];
    exp_t             expQ [$];
    exp_t             e;

    alu_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (loadValid),
        .load_addr  (loadAddr),
        .load_data  (loadData),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .cmd_mode   (cmdMode),
        .cmd_src0   (cmdSrc0),
        .cmd_src1   (cmdSrc1),
        .cmd_dst    (cmdDst),
        .alu_op0    (aluOp0),
        .alu_op1    (aluOp1),
        .alu_mode   (aluMode),
        .alu_result (aluResult),
        .done_valid (doneValid),
        .done_dst   (doneDst),
        .done_data  (doneData),
        .rd_addr    (rdAddr),
        .rd_data    (rdData)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] aluModel(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (m)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign aluResult = aluModel(aluMode, aluOp0, aluOp1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        loadValid = 1'b1;
        loadAddr  = a;
        loadData  = d;
        tick();
        loadValid = 1'b0;
        mreg[a]   = d;
    endtask

    // Raises cmd_valid and records the writeback the model expects from it.
    task automatic drive_cmd(input logic [1:0] m, input logic [AW-1:0] s0,
                             input logic [AW-1:0] s1, input logic [AW-1:0] d);
        exp_t x;
        cmdValid = 1'b1;
        cmdMode  = m;
        cmdSrc0  = s0;
        cmdSrc1  = s1;
        cmdDst   = d;
        x.dst    = d;
        x.data   = aluModel(m, mreg[s0], mreg[s1]);
        expQ.push_back(x);
        mreg[d]  = x.data;
    endtask

    task automatic test_reset();
        rst = 1'b1; loadValid = 1'b0; loadAddr = '0; loadData = '0;
        cmdValid = 1'b0; cmdMode = '0; cmdSrc0 = '0; cmdSrc1 = '0; cmdDst = '0;
        rdAddr = '0;
        for (int i = 0; i < NREGS; i++) mreg[i] = '0;
        tick();
        tick();
        checks++; if (doneValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_done_valid got=%b exp=0", doneValid); end
        checks++; if (aluOp0 !== '0 || aluOp1 !== '0) begin failures++; $display("[TB] FAIL reset_ops got=%h/%h exp=0/0", aluOp0, aluOp1); end
        checks++; if (aluMode !== 2'd0) begin failures++; $display("[TB] FAIL reset_mode got=%0d exp=0", aluMode); end
        checks++; if (doneDst !== '0 || doneData !== '0) begin failures++; $display("[TB] FAIL reset_done_fields got=%0d/%h exp=0/0", doneDst, doneData); end
        rst = 1'b0;
        tick();
        checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_ready got=%b exp=1", cmdReady); end
        for (int i = 0; i < NREGS; i++) begin
            rdAddr = AW'(i);
            #1;
            checks++; if (rdData !== '0) begin failures++; $display("[TB] FAIL reset_reg%0d got=%h exp=0", i, rdData); end
        end
    endtask

    task automatic test_basic();
        do_load(3'd0, 256'd7);
        do_load(3'd1, 256'd13);
        drive_cmd(2'd0, 3'd0, 3'd1, 3'd2);
        tick();
        cmdValid = 1'b0;
        checks++; if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL basic_ready_exec got=%b exp=0", cmdReady); end
        checks++; if (aluOp0 !== 256'd7) begin failures++; $display("[TB] FAIL basic_op0 got=%0d exp=7", aluOp0); end
        checks++; if (aluOp1 !== 256'd13) begin failures++; $display("[TB] FAIL basic_op1 got=%0d exp=13", aluOp1); end
        checks++; if (aluMode !== 2'd0) begin failures++; $display("[TB] FAIL basic_mode got=%0d exp=0", aluMode); end
        checks++; if (doneValid !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_done got=%b exp=0", doneValid); end
        tick();
        e = expQ.pop_front();
        checks++; if (doneValid !== 1'b1) begin failures++; $display("[TB] FAIL basic_done_valid got=%b exp=1", doneValid); end
        checks++; if (doneDst !== e.dst) begin failures++; $display("[TB] FAIL basic_done_dst got=%0d exp=%0d", doneDst, e.dst); end
        checks++; if (doneData !== e.data) begin failures++; $display("[TB] FAIL basic_done_data got=%0d exp=%0d", doneData, e.data); end
        rdAddr = 3'd2;
        #1;
        checks++; if (rdData !== 256'd20) begin failures++; $display("[TB] FAIL basic_rd_r2 got=%0d exp=20", rdData); end
        tick();
        checks++; if (doneValid !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_pulse got=%b exp=0", doneValid); end
        checks++; if (doneDst !== 3'd2 || doneData !== 256'd20) begin failures++; $display("[TB] FAIL basic_done_hold got=%0d/%0d exp=2/20", doneDst, doneData); end
    endtask

    task automatic test_back_to_back();
        do_load(3'd2, 256'd0);
        drive_cmd(2'd0, 3'd0, 3'd1, 3'd2);
        tick();
        drive_cmd(2'd0, 3'd2, 3'd2, 3'd3);
        checks++; if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_exec1 got=%b exp=0", cmdReady); end
        tick();
        e = expQ.pop_front();
        checks++; if (doneValid !== 1'b1 || doneData !== e.data) begin failures++; $display("[TB] FAIL b2b_first_done got=%b/%0d exp=1/%0d", doneValid, doneData, e.data); end
        checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_idle got=%b exp=1", cmdReady); end
        tick();
        cmdValid = 1'b0;
        checks++; if (aluOp0 !== 256'd20 || aluOp1 !== 256'd20) begin failures++; $display("[TB] FAIL b2b_ops got=%0d/%0d exp=20/20", aluOp0, aluOp1); end
        checks++; if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_exec2 got=%b exp=0", cmdReady); end
        checks++; if (doneValid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_gap got=%b exp=0", doneValid); end
        tick();
        e = expQ.pop_front();
        checks++; if (doneValid !== 1'b1 || doneDst !== e.dst || doneData !== e.data) begin
            failures++; $display("[TB] FAIL b2b_second_done got=%b/%0d/%0d exp=1/%0d/%0d", doneValid, doneDst, doneData, e.dst, e.data);
        end
        checks++; if (doneData !== 256'd40) begin failures++; $display("[TB] FAIL b2b_value got=%0d exp=40", doneData); end
    endtask

    task automatic test_wrap();
        do_load(3'd0, {WIDTH{1'b1}});
        do_load(3'd1, 256'd1);
        do_load(3'd4, 256'd55);
        drive_cmd(2'd0, 3'd0, 3'd1, 3'd4);
        tick();
        cmdValid = 1'b0;
        tick();
        e = expQ.pop_front();
        checks++; if (doneValid !== 1'b1 || doneDst !== 3'd4 || doneData !== '0) begin
            failures++; $display("[TB] FAIL wrap_done got=%b/%0d/%h exp=1/4/0", doneValid, doneDst, doneData);
        end
        rdAddr = 3'd4;
        #1;
        checks++; if (rdData !== e.data) begin failures++; $display("[TB] FAIL wrap_r4 got=%h exp=%h", rdData, e.data); end
    endtask

    task automatic test_collision();
        do_load(3'd0, 256'd30);
        do_load(3'd1, 256'd12);
        drive_cmd(2'd0, 3'd0, 3'd1, 3'd5);
        loadValid = 1'b1; loadAddr = 3'd0; loadData = 256'd1000;
        tick();
        cmdValid = 1'b0;
        mreg[0] = 256'd1000;
        loadAddr = 3'd5; loadData = 256'd99;
        checks++; if (aluOp0 !== 256'd30) begin failures++; $display("[TB] FAIL coll_read_before_write got=%0d exp=30", aluOp0); end
        tick();
        loadValid = 1'b0;
        e = expQ.pop_front();
        checks++; if (doneValid !== 1'b1 || doneData !== e.data) begin failures++; $display("[TB] FAIL coll_done got=%b/%0d exp=1/%0d", doneValid, doneData, e.data); end
        rdAddr = 3'd5;
        #1;
        checks++; if (rdData !== 256'd42) begin failures++; $display("[TB] FAIL coll_wb_wins got=%0d exp=42", rdData); end
        rdAddr = 3'd0;
        #1;
        checks++; if (rdData !== mreg[0]) begin failures++; $display("[TB] FAIL coll_load_src got=%0d exp=%0d", rdData, mreg[0]); end
        drive_cmd(2'd0, 3'd0, 3'd1, 3'd5);
        tick();
        cmdValid = 1'b0;
        loadValid = 1'b1; loadAddr = 3'd6; loadData = 256'd99;
        tick();
        loadValid = 1'b0;
        mreg[6] = 256'd99;
        e = expQ.pop_front();
        checks++; if (doneValid !== 1'b1 || doneData !== e.data) begin failures++; $display("[TB] FAIL coll2_done got=%b/%0d exp=1/%0d", doneValid, doneData, e.data); end
        rdAddr = 3'd6;
        #1;
        checks++; if (rdData !== 256'd99) begin failures++; $display("[TB] FAIL coll2_r6 got=%0d exp=99", rdData); end
        rdAddr = 3'd5;
        #1;
        checks++; if (rdData !== 256'd1012) begin failures++; $display("[TB] FAIL coll2_r5 got=%0d exp=1012", rdData); end
    endtask

    task automatic test_mode();
        drive_cmd(2'd3, 3'd0, 3'd1, 3'd7);
        tick();
        cmdValid = 1'b0;
        checks++; if (aluMode !== 2'd3) begin failures++; $display("[TB] FAIL mode3_pass got=%0d exp=3", aluMode); end
        tick();
        e = expQ.pop_front();
        checks++; if (doneValid !== 1'b1 || doneDst !== 3'd7 || doneData !== e.data) begin
            failures++; $display("[TB] FAIL mode3_done got=%b/%0d/%0d exp=1/7/%0d", doneValid, doneDst, doneData, e.data);
        end
        drive_cmd(2'd1, 3'd0, 3'd1, 3'd0);
        tick();
        cmdValid = 1'b0;
        checks++; if (aluMode !== 2'd1 || aluOp0 !== 256'd1000) begin failures++; $display("[TB] FAIL mode1_issue got=%0d/%0d exp=1/1000", aluMode, aluOp0); end
        tick();
        e = expQ.pop_front();
        checks++; if (doneValid !== 1'b1 || doneData !== 256'd988) begin failures++; $display("[TB] FAIL mode1_done got=%b/%0d exp=1/988", doneValid, doneData); end
        rdAddr = 3'd0;
        #1;
        checks++; if (rdData !== e.data) begin failures++; $display("[TB] FAIL dst_eq_src_r0 got=%0d exp=%0d", rdData, e.data); end
    endtask

    task automatic test_reset_midop();
        drive_cmd(2'd0, 3'd0, 3'd1, 3'd2);
        tick();
        cmdValid = 1'b0;
        void'(expQ.pop_back());
        rst = 1'b1;
        #1;
        checks++; if (aluOp0 !== '0 || aluOp1 !== '0 || aluMode !== 2'd0) begin
            failures++; $display("[TB] FAIL midrst_alu_regs got=%h/%h/%0d exp=0/0/0", aluOp0, aluOp1, aluMode);
        end
        tick();
        checks++; if (doneValid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_done_in_rst got=%b exp=0", doneValid); end
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) mreg[i] = '0;
        tick();
        checks++; if (doneValid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_done got=%b exp=0", doneValid); end
        checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready got=%b exp=1", cmdReady); end
        for (int i = 0; i < NREGS; i++) begin
            rdAddr = AW'(i);
            #1;
            checks++; if (rdData !== mreg[i]) begin failures++; $display("[TB] FAIL midrst_reg%0d got=%h exp=0", i, rdData); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_collision();
        test_mode();
        test_reset_midop();
        checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", expQ.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
